coin_acceptor: RTL

Front-end for the vending machine's 2-bit coin input. Synchronizes and debounces the two raw coin-mechanism detectors, queues qualified coins in a small FIFO, and replays them to the vending FSM as single-cycle coin codes with a guaranteed idle gap. It also drives the return-flap reject pulse. It sits between the coin mechanism pins and the vending FSM's `in[1:0]` port.

---
 rtl/vending_pkg.sv | 32 +++
 rtl/coin_debounce.sv | 53 +++++
 rtl/coin_acceptor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : vending_pkg                                                    |
// | Brief   : Coin codes, coin values and emit-FSM state shared by the       |
// |           vending machine coin front-end.                                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  localparam logic [15:0] COIN_VAL_5  = 16'd5;
  localparam logic [15:0] COIN_VAL_10 = 16'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } emit_state_t;

  function automatic logic [15:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  return COIN_VAL_5;
      COIN_10: return COIN_VAL_10;
      default: return 16'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/coin_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : coin_debounce                                                  |
// | Brief   : 2-FF synchronizer plus saturating debounce counter; emits one  |
// |           qualify pulse per insertion.                                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module coin_debounce
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic det,
  output logic qualify
);

  localparam logic [7:0] C_TARGET = 8'(DEBOUNCE);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_armed;
  logic [7:0] r_cnt;

  // Counter sits at the target while the coin stays; the arm flag stops repeats.
  assign qualify = r_armed && (r_cnt == C_TARGET);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_sync1 <= det;
      r_sync2 <= r_sync1;
      if (!r_sync2) begin
        r_cnt   <= 8'd0;
        r_armed <= 1'b1;
      end else begin
        if (r_cnt != C_TARGET) begin
          r_cnt <= r_cnt + 8'd1;
        end
        if (qualify) begin
          r_armed <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : coin_acceptor                                                  |
// | Brief   : Debounces the coin detectors, queues coins and replays them as |
// |           single-cycle codes with an idle gap. Optional statistics ports |
// |           are enabled by defining COIN_ACCEPTOR_STATS_EN.                |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 8,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned GAP      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     det5,
  input  logic                     det10,
  input  logic                     enable,
  output logic [1:0]               coin,
  output logic                     reject,
  output logic [$clog2(DEPTH):0]   level
`ifdef COIN_ACCEPTOR_STATS_EN
  ,
  output logic [15:0]              credit_total,
  output logic [7:0]               reject_cnt
`endif
);

  localparam int unsigned     C_AW   = $clog2(DEPTH);
  localparam logic [C_AW:0]   C_FULL = (C_AW + 1)'(DEPTH);
  localparam logic [3:0]      C_GAP  = 4'(GAP);

  logic [1:0]      w_det;
  logic [1:0]      w_qual;
  logic            w_q5;
  logic            w_q10;
  logic            w_push_req;
  logic [1:0]      w_push_code;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  logic            w_reject_set;

  logic [1:0]      r_mem [DEPTH];
  logic [C_AW-1:0] r_wr_ptr;
  logic [C_AW-1:0] r_rd_ptr;
  logic [C_AW:0]   r_level;
  logic            r_reject;

  emit_state_t     r_state;
  emit_state_t     w_state_next;
  logic [3:0]      r_gap_cnt;
  logic [3:0]      w_gap_next;
  logic [1:0]      r_coin;
  logic [1:0]      w_coin_next;

  assign w_det = {det10, det5};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    coin_debounce #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .det     (w_det[gi]),
      .qualify (w_qual[gi])
    );
  end

  assign w_q5         = w_qual[0];
  assign w_q10        = w_qual[1];
  assign w_push_req   = w_q5 ^ w_q10;
  assign w_push_code  = w_q5 ? COIN_5 : COIN_10;
  assign w_empty      = (r_level == '0);
  assign w_full       = (r_level == C_FULL);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push       = w_push_req && (!w_full || w_pop);
  assign w_reject_set = (w_q5 && w_q10) || (w_push_req && w_full && !w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_push_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_reject <= 1'b0;
    end else begin
      r_reject <= w_reject_set;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= 4'd0;
      r_coin    <= COIN_NONE;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_next;
      r_coin    <= w_coin_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_gap_next   = r_gap_cnt;
    w_coin_next  = COIN_NONE;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_EMIT;
          w_coin_next  = r_mem[r_rd_ptr];
        end
      end
      ST_EMIT: begin
        w_state_next = ST_GAP;
        w_gap_next   = C_GAP;
      end
      ST_GAP: begin
        // The final gap cycle takes the idle decision itself, so queued
        // codes are separated by exactly GAP zero cycles.
        if (r_gap_cnt > 4'd1) begin
          w_gap_next = r_gap_cnt - 4'd1;
        end else if (enable && !w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_EMIT;
          w_coin_next  = r_mem[r_rd_ptr];
          w_gap_next   = 4'd0;
        end else begin
          w_state_next = ST_IDLE;
          w_gap_next   = 4'd0;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_gap_next   = 4'd0;
      end
    endcase
  end

  assign coin   = r_coin;
  assign reject = r_reject;
  assign level  = r_level;

`ifdef COIN_ACCEPTOR_STATS_EN
  logic [15:0] r_credit;
  logic [7:0]  r_rej_cnt;
  logic [16:0] w_credit_sum;

  assign w_credit_sum = {1'b0, r_credit} + {1'b0, coin_value(w_coin_next)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit  <= 16'd0;
      r_rej_cnt <= 8'd0;
    end else begin
      if (w_pop) begin
        r_credit <= w_credit_sum[16] ? 16'hFFFF : w_credit_sum[15:0];
      end
      if (r_reject && (r_rej_cnt != 8'hFF)) begin
        r_rej_cnt <= r_rej_cnt + 8'd1;
      end
    end
  end

  assign credit_total = r_credit;
  assign reject_cnt   = r_rej_cnt;
`endif

endmodule
`default_nettype wire
